// File: rtl/qtcore_serial_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | qtcore_serial_bridge                                                     |
// | Framed serial port driving NUM_CHAINS scan chains and processor control. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module qtcore_serial_bridge #(
  parameter int NUM_CHAINS = 2,
  parameter int STEP_W     = 6,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic [NUM_CHAINS-1:0] scan_enable,
  output logic                  scan_in,
  input  logic [NUM_CHAINS-1:0] scan_out,
  output logic                  proc_en,
  input  logic                  halt
);

  localparam int           c_SR_W     = CNT_W + 8;
  localparam logic [6:0]   c_NUM_CH   = 7'(NUM_CHAINS);
  localparam logic [1:0]   c_OP_SCAN  = 2'b00;
  localparam logic [1:0]   c_OP_RUN   = 2'b01;
  localparam logic [1:0]   c_OP_STEP  = 2'b10;
  localparam logic [STEP_W:0] c_STEP_ONE = (STEP_W+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_SCAN   = 3'd2,
    S_RUN    = 3'd3,
    S_STAT   = 3'd4,
    S_IGNORE = 3'd5
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic [2:0]              r_bit_cnt, w_bit_cnt_nxt;
  logic [6:0]              r_cmd_sr;
  logic [7:0]              w_cmd;
  logic                    w_decode, w_step_start, w_stat_load, w_stat_clear;
  logic                    w_chan_ok;
  logic [NUM_CHAINS-1:0]   w_chan_sel, r_chan_sel;
  logic                    r_clr;
  logic                    r_busy, w_busy_nxt;
  logic [STEP_W:0]         r_step_cnt, w_step_load;
  logic                    r_proc_en, w_proc_en_nxt;
  logic [CNT_W-1:0]        r_cycle_cnt;
  logic [c_SR_W-1:0]       r_status_sr;

  assign scan_in     = mosi;
  assign proc_en     = r_proc_en;
  assign w_step_load = {1'b0, STEP_W'(w_cmd[5:0])} + c_STEP_ONE;

  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_decode      = 1'b0;
    w_step_start  = 1'b0;
    w_stat_load   = 1'b0;
    w_cmd         = {r_cmd_sr, mosi};
    w_chan_ok     = ({1'b0, w_cmd[5:0]} < c_NUM_CH);
    for (int i = 0; i < NUM_CHAINS; i++) begin
      w_chan_sel[i] = (w_cmd[5:0] == 6'(i));
    end
    if (cs_n) begin
      w_state_nxt   = S_IDLE;
      w_bit_cnt_nxt = 3'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt   = S_CMD;
          w_bit_cnt_nxt = 3'd1;
        end
        S_CMD: begin
          w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            w_decode = 1'b1;
            case (w_cmd[7:6])
              c_OP_SCAN: w_state_nxt = (w_chan_ok && !r_busy) ? S_SCAN : S_IGNORE;
              c_OP_RUN:  w_state_nxt = r_busy ? S_IGNORE : S_RUN;
              c_OP_STEP: begin
                w_state_nxt  = S_IGNORE;
                w_step_start = !r_busy;
              end
              default: begin
                w_state_nxt = S_STAT;
                w_stat_load = 1'b1;
              end
            endcase
          end
        end
        default: w_state_nxt = r_state;
      endcase
    end

    // The step engine runs regardless of the frame; a halt ends it at once.
    if (r_busy) begin
      w_busy_nxt = !(halt || (r_step_cnt == c_STEP_ONE));
    end else begin
      w_busy_nxt = w_step_start;
    end
    w_proc_en_nxt = w_busy_nxt || ((r_state == S_RUN) && !cs_n && !halt);
    w_stat_clear  = (r_state == S_STAT) && cs_n && r_clr;

    scan_enable = '0;
    miso        = 1'b0;
    case (r_state)
      S_SCAN: begin
        scan_enable = cs_n ? '0 : r_chan_sel;
        miso        = |(scan_out & r_chan_sel);
      end
      S_RUN:    miso = halt;
      S_STAT:   miso = r_status_sr[c_SR_W-1];
      S_IGNORE: miso = r_busy;
      default:  miso = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= 3'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd_sr   <= '0;
      r_chan_sel <= '0;
      r_clr      <= 1'b0;
    end else begin
      if (!cs_n && ((r_state == S_IDLE) || (r_state == S_CMD))) begin
        r_cmd_sr <= {r_cmd_sr[5:0], mosi};
      end
      if (w_decode) begin
        r_chan_sel <= w_chan_sel;
        r_clr      <= w_cmd[0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy     <= 1'b0;
      r_step_cnt <= '0;
      r_proc_en  <= 1'b0;
    end else begin
      r_busy    <= w_busy_nxt;
      r_proc_en <= w_proc_en_nxt;
      if (r_busy) begin
        r_step_cnt <= w_busy_nxt ? (r_step_cnt - c_STEP_ONE) : '0;
      end else if (w_step_start) begin
        r_step_cnt <= w_step_load;
      end
    end
  end

  // A clear on the frame-ending edge takes priority over a same-edge increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle_cnt <= '0;
      r_status_sr <= '0;
    end else begin
      if (w_stat_clear) begin
        r_cycle_cnt <= '0;
      end else if (r_proc_en && (r_cycle_cnt != {CNT_W{1'b1}})) begin
        r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
      end
      if (w_stat_load) begin
        r_status_sr <= {halt, r_busy, 6'b0, r_cycle_cnt};
      end else if ((r_state == S_STAT) && !cs_n) begin
        r_status_sr <= {r_status_sr[c_SR_W-2:0], 1'b0};
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_qtcore_serial_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_qtcore_serial_bridge                                                  |
// | Frame-level stimulus against a bit-queue reference of the bridge.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_qtcore_serial_bridge;

  localparam int NC = 2;

  logic          clk;
  logic          rst, cs_n, mosi, halt;
  logic [NC-1:0] scan_out;
  logic          miso, scan_in, proc_en;
  logic [NC-1:0] scan_enable;
  logic          miso2, scan_in2, proc_en2;
  logic [NC-1:0] scan_enable2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  qtcore_serial_bridge #(.NUM_CHAINS(NC), .STEP_W(6), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .scan_enable(scan_enable), .scan_in(scan_in), .scan_out(scan_out),
    .proc_en(proc_en), .halt(halt)
  );

  // Narrow counter instance so saturation is reachable in a short run.
  qtcore_serial_bridge #(.NUM_CHAINS(NC), .STEP_W(6), .CNT_W(6)) dut2 (
    .clk(clk), .rst(rst), .cs_n(cs_n), .mosi(mosi), .miso(miso2),
    .scan_enable(scan_enable2), .scan_in(scan_in2), .scan_out(scan_out),
    .proc_en(proc_en2), .halt(halt)
  );

  int errors = 0;
  int checks = 0;

  // Reference: frame position, decoded mode, step budget, and status as bit queues.
  bit m_valid = 1'b0;
  int m_mode;   // 0 idle, 1 command, 2 scan, 3 run, 4 stat, 5 ignore
  int m_nbits, m_cmd, m_chan, m_left, m_cycles;
  bit m_clr, m_busy, m_pe;
  bit m_q1[$];
  bit m_q2[$];

  int            cnt_pe, cnt_en;
  logic [NC-1:0] or_en;
  logic [23:0]   rd1, rd2;
  logic          s_miso, s_miso2, s_pe;
  logic [NC-1:0] s_en;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int w);
    return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
  endfunction

  task automatic model_reset();
    m_valid = 1'b1; m_mode = 0; m_nbits = 0; m_cmd = 0; m_chan = 0;
    m_left = 0; m_cycles = 0; m_clr = 1'b0; m_busy = 1'b0; m_pe = 1'b0;
    m_q1 = {}; m_q2 = {};
  endtask

  task automatic check_cycle();
    logic [NC-1:0] e_en;
    logic          e_m1, e_m2;
    if (!m_valid) return;
    e_en = (m_mode == 2 && !cs_n) ? (NC'(1) << m_chan) : '0;
    case (m_mode)
      2: begin e_m1 = scan_out[m_chan]; e_m2 = e_m1; end
      3: begin e_m1 = halt; e_m2 = halt; end
      4: begin
        e_m1 = (m_q1.size() > 0) ? m_q1[0] : 1'b0;
        e_m2 = (m_q2.size() > 0) ? m_q2[0] : 1'b0;
      end
      5: begin e_m1 = m_busy; e_m2 = m_busy; end
      default: begin e_m1 = 1'b0; e_m2 = 1'b0; end
    endcase
    chk("scan_enable", 32'(scan_enable), 32'(e_en));
    chk("scan_enable2", 32'(scan_enable2), 32'(e_en));
    chk("miso", 32'(miso), 32'(e_m1));
    chk("miso2", 32'(miso2), 32'(e_m2));
    chk("proc_en", 32'(proc_en), 32'(m_pe));
    chk("proc_en2", 32'(proc_en2), 32'(m_pe));
    chk("scan_in", {30'b0, scan_in, scan_in2}, {30'b0, mosi, mosi});
    chk("mutex", 32'(proc_en & (|scan_enable)), 32'd0);
  endtask

  task automatic model_edge();
    bit old_busy;
    int old_cycles, op, arg, v;
    bit pe_run, start;
    if (rst) begin model_reset(); return; end
    old_busy   = m_busy;
    old_cycles = m_cycles;
    start      = 1'b0;
    arg        = 0;
    pe_run     = (m_mode == 3) && !cs_n && !halt;
    if (m_pe) m_cycles++;
    if (cs_n) begin
      if (m_mode == 4 && m_clr) m_cycles = 0;
      m_mode = 0; m_nbits = 0; m_cmd = 0;
    end else if (m_mode <= 1) begin
      m_mode  = 1;
      m_cmd   = (m_cmd << 1) | int'(mosi);
      m_nbits = m_nbits + 1;
      if (m_nbits == 8) begin
        op  = (m_cmd >> 6) & 3;
        arg = m_cmd & 63;
        case (op)
          0: begin m_mode = (arg < NC && !old_busy) ? 2 : 5; m_chan = arg; end
          1: m_mode = old_busy ? 5 : 3;
          2: begin m_mode = 5; start = !old_busy; end
          default: begin
            m_mode = 4; m_clr = arg[0];
            m_q1 = {}; m_q2 = {};
            m_q1.push_back(bit'(halt)); m_q1.push_back(old_busy);
            m_q2.push_back(bit'(halt)); m_q2.push_back(old_busy);
            repeat (6) begin m_q1.push_back(1'b0); m_q2.push_back(1'b0); end
            v = sat(old_cycles, 16);
            for (int b = 15; b >= 0; b--) m_q1.push_back(bit'((v >> b) & 1));
            v = sat(old_cycles, 6);
            for (int b = 5; b >= 0; b--) m_q2.push_back(bit'((v >> b) & 1));
          end
        endcase
      end
    end else if (m_mode == 4) begin
      if (m_q1.size() > 0) void'(m_q1.pop_front());
      if (m_q2.size() > 0) void'(m_q2.pop_front());
    end
    if (old_busy) begin
      m_left = m_left - 1;
      if (m_left == 0 || halt) m_busy = 1'b0;
    end else if (start) begin
      m_busy = 1'b1; m_left = arg + 1;
    end
    m_pe = m_busy || pe_run;
  endtask

  // One clock: drive inputs, sample mid-cycle, update the reference at the edge.
  task automatic cyc(input logic c, input logic d);
    cs_n = c; mosi = d;
    scan_out = NC'($urandom);
    @(negedge clk);
    check_cycle();
    s_miso = miso; s_miso2 = miso2; s_pe = proc_en; s_en = scan_enable;
    if (proc_en) cnt_pe++;
    if (scan_enable != '0) cnt_en++;
    or_en = or_en | scan_enable;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_halt(input int hf, input int k);
    if (hf == -2) halt = ($urandom_range(0, 9) == 0);
    else          halt = (hf >= 0 && k >= hf);
  endtask

  task automatic frame(input logic [7:0] cmd, input int nbits, input logic [31:0] pay,
                       input int halt_from, input int tail);
    int k = 0;
    cnt_pe = 0; cnt_en = 0; or_en = '0; rd1 = '0; rd2 = '0;
    for (int i = 7; i >= 0; i--) begin set_halt(halt_from, k); cyc(1'b0, cmd[i]); k++; end
    for (int i = nbits - 1; i >= 0; i--) begin
      set_halt(halt_from, k);
      cyc(1'b0, pay[i]);
      rd1 = {rd1[22:0], s_miso};
      rd2 = {rd2[22:0], s_miso2};
      k++;
    end
    for (int i = 0; i < tail; i++) begin set_halt(halt_from, k); cyc(1'b1, 1'b0); k++; end
    halt = 1'b0;
  endtask

  typedef struct {
    logic [7:0]    cmd;
    int            nbits;
    logic [31:0]   pay;
    int            halt_from;
    int            en_cycles;
    logic [NC-1:0] en_mask;
    int            pe_cycles;
  } vec_t;

  vec_t vt[7];

  initial begin
    vt[0] = '{8'h01, 10, 32'b1011001110, -1, 10, 2'b10, 0};
    vt[1] = '{8'h05,  6, 32'h2D,         -1,  0, 2'b00, 0};
    vt[2] = '{8'h00,  5, 32'h15,         -1,  5, 2'b01, 0};
    vt[3] = '{8'h02,  3, 32'h7,          -1,  0, 2'b00, 0};
    vt[4] = '{8'h40, 20, 32'h0,          20,  0, 2'b00, 12};
    vt[5] = '{8'h83,  0, 32'h0,           9,  0, 2'b00, 2};
    vt[6] = '{8'h83,  0, 32'h0,          -1,  0, 2'b00, 4};

    rst = 1'b1; cs_n = 1'b1; mosi = 1'b0; halt = 1'b1; scan_out = '0;
    cnt_pe = 0; cnt_en = 0; or_en = '0;
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    rst = 1'b0;
    cyc(1'b1, 1'b0);
    chk("reset_outputs", {s_en, s_miso, s_pe}, 32'd0);
    chk("reset_outputs2", {scan_enable2, miso2, proc_en2}, 32'd0);
    frame(8'hC1, 24, 32'h0, 0, 2);
    chk("reset_stat", 32'(rd1), 32'h800000);
    chk("reset_stat2", 32'(rd2), 32'h800000);

    frame(8'h83, 0, 32'h0, -1, 6);
    chk("step4_proc_en", cnt_pe, 4);
    frame(8'hC1, 24, 32'h0, -1, 2);
    chk("step4_stat", 32'(rd1), 32'h000004);
    chk("step4_stat2", 32'(rd2), 32'h001000);

    for (int i = 0; i < 7; i++) begin
      frame(vt[i].cmd, vt[i].nbits, vt[i].pay, vt[i].halt_from, 6);
      chk($sformatf("vec%0d_en_cycles", i), cnt_en, vt[i].en_cycles);
      chk($sformatf("vec%0d_en_mask", i), 32'(or_en), 32'(vt[i].en_mask));
      chk($sformatf("vec%0d_pe_cycles", i), cnt_pe, vt[i].pe_cycles);
    end

    // Commands issued while a long step is active are ignored.
    frame(8'hBF, 0, 32'h0, -1, 6);
    frame(8'h00, 2, 32'h3, -1, 6);
    chk("busy_scan_ignored", cnt_en, 0);
    frame(8'h40, 2, 32'h0, -1, 6);
    chk("busy_run_ignored", cnt_en, 0);
    frame(8'hC1, 24, 32'h0, 12, 2);
    chk("busy_stat_busy_bit", 32'(rd1[22]), 32'd1);
    frame(8'hC0, 24, 32'h0, -1, 2);
    chk("busy_stat_cleared", 32'(rd1), 32'h000000);

    frame(8'hBF, 0, 32'h0, -1, 3);
    rst = 1'b1;
    cyc(1'b1, 1'b0);
    chk("pre_rst_step_pe", 32'(s_pe), 32'd1);
    rst = 1'b0;
    cyc(1'b1, 1'b0);
    chk("rst_mid_step_pe", 32'(s_pe), 32'd0);
    for (int i = 7; i >= 0; i--) cyc(1'b0, i == 0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1);
    rst = 1'b1;
    cyc(1'b0, 1'b1);
    chk("pre_rst_scan_en", 32'(s_en), 32'h2);
    rst = 1'b0;
    cyc(1'b1, 1'b0);
    chk("rst_mid_scan", {s_en, s_miso, s_pe}, 32'd0);
    frame(8'hC0, 24, 32'h0, -1, 2);
    chk("rst_stat", 32'(rd1), 32'h000000);

    frame(8'hBF, 0, 32'h0, -1, 70);
    frame(8'hC0, 24, 32'h0, -1, 2);
    chk("sat_stat", 32'(rd1), 32'h000040);
    chk("sat_stat2", 32'(rd2), 32'h00FC00);

    for (int f = 0; f < 60; f++) begin
      int op, arg;
      op = $urandom_range(0, 3);
      case (op)
        0: arg = $urandom_range(0, 3);
        2: arg = $urandom_range(0, 15);
        default: arg = $urandom_range(0, 63);
      endcase
      if ($urandom_range(0, 7) == 0) begin
        int n = $urandom_range(1, 7);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'($urandom));
        cyc(1'b1, 1'b0);
      end else begin
        frame({2'(op), 6'(arg)}, $urandom_range(0, 12), $urandom, -2, $urandom_range(1, 4));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
